mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the processor's single unified 16-bit instruction/data memory port between three requesters: instruction fetch (port 0), data load/store (port 1) and the program loader/debug port (port 2).
- Replaces the direct IorD address mux. The control FSM raises per-port requests and stalls until the matching response arrives.
- One transaction is outstanding at a time. The memory has a fixed, parameterised read latency.

Parameters:
AW, 16, address width
DW, 16, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..7
CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > MEM_LAT

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req  input  3  per-port request; bit i belongs to port i
we  input  3  per-port write enable, sampled together with req
addr  input  3*AW  per-port address, packed; port i occupies [i*AW +: AW]
wdata  input  3*DW  per-port write data, packed the same way
gnt  output  3  one-cycle grant pulse to the winning port
rsp_valid  output  3  one-cycle completion pulse to the winning port
rsp_rdata  output  DW  read data, shared by all ports, qualified by rsp_valid
busy  output  1  high whenever state is not IDLE
mem_en  output  1  memory access strobe, one cycle per transaction
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 immediately.
  - State goes to IDLE; the latency counter clears.
  - rr_last is set to 1 (port 1), so fetch wins the first tie after reset.
  - A transaction in flight is abandoned: no rsp_valid is issued for it. A write that already had its mem_en edge may have been committed.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until the cycle gnt is seen.
  - Keeping req high after gnt requests a new transaction.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, at cycle T, when req != 0:
  - Pick the winner: port 2 has strict priority. Otherwise, if both ports 0 and 1 request, take the one that is not rr_last. Otherwise take the single requester.
  - Latch winner id, we, addr and wdata into internal registers.
  - Move to ACCESS and load cnt with MEM_LAT.
  - When req == 0, stay in IDLE with all strobes low.
- First cycle of ACCESS (T+1):
  - gnt[id]=1 and mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven from the latches.
  - If id is 0 or 1, rr_last is set to id. A port-2 grant leaves rr_last unchanged.
- Rest of ACCESS:
  - mem_en=0 after the first cycle; mem_addr and mem_wdata hold their latched values.
  - cnt decrements every cycle.
  - When cnt==1, capture mem_rdata into the read latch (or 0 for a write) and move to RESP.
- RESP (T+1+MEM_LAT):
  - rsp_valid[id]=1 for one cycle.
  - rsp_rdata carries the read latch; it is 0 for writes.
  - Next state is IDLE unconditionally.
- Timing:
  - Latency from req sampled to rsp_valid is MEM_LAT+1 cycles.
  - Throughput is one transaction per MEM_LAT+2 cycles.
  - Writes take the same timing as reads; the memory commits the write on the mem_en edge.
- Other outputs:
  - rsp_rdata holds its last value when rsp_valid=0.
  - gnt, rsp_valid and mem_en are registered and glitch-free.
  - Only one bit of gnt or rsp_valid is ever high in any cycle.
- Boundary cases:
  - A req that arrives during ACCESS or RESP is ignored until IDLE.
  - A req dropped before it is granted never receives a gnt.
  - Address and data are forwarded as-is; there is no wrap or width conversion.

Decomposition:
- Shared package holds:
  - AW and DW defaults.
  - Port index constants: PORT_IF=0, PORT_LS=1, PORT_LD=2.
  - State encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
- One combinational sub-module, arb_picker:
  - Inputs: req[2:0] and rr_last.
  - Outputs: winner id[1:0] and a valid flag.
  - Unit-testable on its own.

Test Plan:
1. Single read, MEM_LAT=1: req=3'b001 with addr0=16'h0004; memory word 4 = 16'hA1B2 -> gnt=001 at T+1 with mem_en=1 and mem_addr=4; rsp_valid=001 and rsp_rdata=16'hA1B2 at T+2; busy high for T+1..T+2.
2. Write, MEM_LAT=3: req=3'b010, we=3'b010, addr1=16'h0009, wdata1=16'h1234 -> mem_en=1, mem_we=1, mem_addr=9, mem_wdata=16'h1234 at T+1; rsp_valid=010 at T+4 with rsp_rdata=0; a later read of address 9 returns 16'h1234.
3. Round-robin fairness: ports 0 and 1 hold req high continuously after reset -> grant order 0,1,0,1, with gnt pulses spaced MEM_LAT+2 cycles apart.
4. Loader priority: req=3'b111 -> port 2 is granted first; then ports 0 and 1 follow in round-robin order; rr_last is unaffected by the port-2 grant.
5. Reset mid-transaction: assert reset=0 during ACCESS when MEM_LAT=3 -> all outputs go to 0 asynchronously; no rsp_valid is issued; after release, a pending port-0 request is granted again.
6. Late and dropped requests: a port-1 req raised during ACCESS is granted only after RESP; a port-0 req pulsed for one cycle during ACCESS never receives a gnt.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, port ids and FSM encoding for the memory port arbiter.
package mem_port_arbiter_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam logic [1:0] PORT_IF = 2'd0;
    localparam logic [1:0] PORT_LS = 2'd1;
    localparam logic [1:0] PORT_LD = 2'd2;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;
endpackage

// File: rtl/mem_port_arbiter_arb_picker.sv
// arb_picker: loader wins outright; fetch and load/store alternate on a tie.
module arb_picker (
    input  logic [2:0] req,
    input  logic       rr_last,
    output logic [1:0] id,
    output logic       valid
);
    import mem_port_arbiter_pkg::*;
    always_comb begin
        valid = |req;
        id    = req[2] ? PORT_LD :
                (&req[1:0]) ? (rr_last ? PORT_IF : PORT_LS) :
                req[1] ? PORT_LS : PORT_IF;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified instruction/data memory port between three requesters,
// one transaction in flight, fixed read latency MEM_LAT.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]      gnt,
    output logic [2:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            busy,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_last_q, rr_last_d;
    logic [1:0]       id_q, id_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [2:0]       rsp_q, rsp_d;
    logic             en_q, en_d;
    logic [1:0]       pick_id;
    logic             pick_valid;

    arb_picker u_pick (
        .req     (req),
        .rr_last (rr_last_q),
        .id      (pick_id),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        gnt_d     = '0;
        rsp_d     = '0;
        en_d      = 1'b0;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(MEM_LAT);
                id_d    = pick_id;
                we_d    = we[pick_id];
                addr_d  = addr[int'(pick_id)*AW +: AW];
                wdata_d = wdata[int'(pick_id)*DW +: DW];
                gnt_d   = 3'b001 << pick_id;
                en_d    = 1'b1;
            end
            ACCESS: begin
                cnt_d = cnt_q - 1'b1;
                // en_q marks the first ACCESS cycle; loader grants leave the tie-break alone
                if (en_q && id_q != PORT_LD) rr_last_d = id_q[0];
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : mem_rdata;
                    rsp_d   = 3'b001 << id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_last_q <= 1'b1;
            id_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            gnt_q     <= '0;
            rsp_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            gnt_q     <= gnt_d;
            rsp_q     <= rsp_d;
            en_q      <= en_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign busy      = state_q != IDLE;
    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model
// that predicts each cycle's outputs from the accepted transaction's start cycle.
module tb_mem_port_arbiter;
    localparam int LAT = 3;
    logic clk = 1'b0, reset = 1'b0;
    logic [2:0] req = '0, we = '0;
    logic [2:0][15:0] addr = '0, wdata = '0;
    logic [2:0] gnt, rsp_valid;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic busy, mem_en, mem_we;
    logic [15:0] dev_mem [16];
    logic [15:0] ref_mem [16];
    int checks = 0, fails = 0, cyc = 0, t_start = -100;
    logic [1:0] t_id = '0;
    logic t_we = 1'b0, rr = 1'b1, e_we = 1'b0;
    logic [15:0] t_addr = '0, t_wdata = '0, t_rd = '0, e_addr = '0, e_wdata = '0, e_rdata = '0;
    logic [56:0] obs, exp_v;

    assign obs = {gnt, rsp_valid, mem_en, busy, mem_we, mem_addr, mem_wdata, rsp_rdata};
    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] init_val(input int i);
        return (i == 4) ? 16'hA1B2 : 16'(i * 3167 + 4096);
    endfunction

    // memory device: address held through ACCESS, so a plain array read meets any latency
    assign mem_rdata = dev_mem[mem_addr[3:0]];
    always @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < 16; i++) dev_mem[i] <= init_val(i);
        else if (mem_en && mem_we) dev_mem[mem_addr[3:0]] <= mem_wdata;

    task automatic model_eval();
        if (cyc == t_start + 1) begin
            e_we = t_we; e_addr = t_addr; e_wdata = t_wdata;
        end
        if (cyc == t_start + 1 + LAT) e_rdata = t_rd;
        exp_v = {(cyc == t_start + 1) ? 3'(1 << t_id) : 3'b0,
                 (cyc == t_start + 1 + LAT) ? 3'(1 << t_id) : 3'b0,
                 cyc == t_start + 1, cyc >= t_start + 1 && cyc <= t_start + 1 + LAT,
                 e_we, e_addr, e_wdata, e_rdata};
    endtask

    task automatic model_reset();
        t_start = -100; rr = 1'b1;
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        model_eval();
    endtask

    // accept a transaction from this cycle's inputs if the port is free, then advance one cycle
    task automatic tick();
        if (cyc > t_start + LAT + 1 && req != 3'b0) begin
            t_start = cyc;
            t_id = req[2] ? 2'd2 : (&req[1:0]) ? 2'(1 - int'(rr)) : (req[0] ? 2'd0 : 2'd1);
            if (t_id != 2'd2) rr = t_id[0];
            t_we = we[t_id]; t_addr = addr[t_id]; t_wdata = wdata[t_id];
            t_rd = t_we ? 16'h0 : ref_mem[t_addr[3:0]];
            if (t_we) ref_mem[t_addr[3:0]] = t_wdata;
        end
        @(posedge clk); cyc++; @(negedge clk);
        model_eval();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (obs !== 57'h0) begin fails++; $display("FAIL reset_hold got %h want 0", obs); end
        @(negedge clk); reset = 1'b1; cyc = 0; model_reset();
        checks++; if (obs !== exp_v || busy !== 1'b0) begin fails++; $display("FAIL reset_release got %h want %h", obs, exp_v); end
        repeat (3) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL reset_idle c%0d got %h want %h", cyc, obs, exp_v); end
        end
    endtask

    task automatic test_round_robin();
        int ids[$], at[$];
        req = 3'b011; we = 3'b000; addr[0] = 16'h0001; addr[1] = 16'h0002;
        for (int k = 0; k < 4 * (LAT + 2) + 2; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL rr c%0d got %h want %h", cyc, obs, exp_v); end
            if (gnt != 3'b0) begin ids.push_back(gnt[1] ? 1 : gnt[2] ? 2 : 0); at.push_back(cyc); end
            if (ids.size() == 4) req = 3'b000;
        end
        checks++;
        if (ids.size() != 4) begin fails++; $display("FAIL rr_count got %0d grants want 4", ids.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (ids[i] != i % 2 || (i > 0 && at[i] - at[i-1] != LAT + 2)) begin
                fails++; $display("FAIL rr_order grant %0d got port %0d at c%0d want port %0d", i, ids[i], at[i], i % 2);
            end
        end
    endtask

    task automatic test_single_read();
        req = 3'b001; we = 3'b000; addr[0] = 16'h0004;
        tick();
        checks++;
        if (obs !== exp_v || gnt !== 3'b001 || mem_en !== 1'b1 || mem_addr !== 16'h0004 || busy !== 1'b1) begin
            fails++; $display("FAIL read_issue got %h want %h", obs, exp_v);
        end
        req = 3'b000;
        for (int k = 0; k < LAT; k++) begin
            tick();
            checks++; if (obs !== exp_v || busy !== 1'b1) begin fails++; $display("FAIL read_wait c%0d got %h want %h", cyc, obs, exp_v); end
        end
        checks++; if (rsp_valid !== 3'b001 || rsp_rdata !== 16'hA1B2) begin fails++; $display("FAIL read_rsp got %b/%h want 001/a1b2", rsp_valid, rsp_rdata); end
        tick();
        checks++; if (obs !== exp_v || busy !== 1'b0) begin fails++; $display("FAIL read_idle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_write();
        req = 3'b010; we = 3'b010; addr[1] = 16'h0009; wdata[1] = 16'h1234;
        tick();
        checks++;
        if (obs !== exp_v || gnt !== 3'b010 || {mem_en, mem_we} !== 2'b11 || mem_addr !== 16'h0009 || mem_wdata !== 16'h1234) begin
            fails++; $display("FAIL write_issue got %h want %h", obs, exp_v);
        end
        req = 3'b000; we = 3'b000;
        for (int k = 0; k < LAT; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL write_wait c%0d got %h want %h", cyc, obs, exp_v); end
        end
        checks++; if (rsp_valid !== 3'b010 || rsp_rdata !== 16'h0) begin fails++; $display("FAIL write_rsp got %b/%h want 010/0000", rsp_valid, rsp_rdata); end
        tick();
        req = 3'b001; addr[0] = 16'h0009;
        tick();
        req = 3'b000;
        for (int k = 0; k < LAT; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL readback_wait c%0d got %h want %h", cyc, obs, exp_v); end
        end
        checks++; if (rsp_valid !== 3'b001 || rsp_rdata !== 16'h1234) begin fails++; $display("FAIL readback got %b/%h want 001/1234", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_priority();
        int code = 0, want;
        want = 200 + 10 * (1 - int'(rr)) + int'(rr);
        req = 3'b111; we = 3'b000;
        for (int i = 0; i < 3; i++) addr[i] = 16'($urandom);
        for (int k = 0; k < 4 * (LAT + 2); k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL prio c%0d got %h want %h", cyc, obs, exp_v); end
            for (int i = 0; i < 3; i++) if (gnt[i]) begin code = code * 10 + i; req[i] = 1'b0; end
        end
        checks++; if (code != want) begin fails++; $display("FAIL prio_order got %0d want %0d", code, want); end
    endtask

    task automatic test_late_drop();
        int c0, g1_at = -1, g0_cnt = 0;
        req = 3'b001; we = 3'b000; addr[0] = 16'($urandom); addr[1] = 16'($urandom);
        c0 = cyc;
        tick();
        checks++; if (obs !== exp_v || gnt !== 3'b001) begin fails++; $display("FAIL late_first got %h want %h", obs, exp_v); end
        req = 3'b010;
        tick();
        req = 3'b011;
        tick();
        req = 3'b010;
        for (int k = 0; k < 2 * (LAT + 2) + 4; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL late c%0d got %h want %h", cyc, obs, exp_v); end
            if (gnt[0]) g0_cnt++;
            if (gnt[1] && g1_at < 0) begin g1_at = cyc; req = 3'b000; end
        end
        checks++;
        if (g0_cnt != 0 || g1_at != c0 + 3 + LAT) begin
            fails++; $display("FAIL late_drop got gnt0 x%0d gnt1 at c%0d want x0 at c%0d", g0_cnt, g1_at, c0 + 3 + LAT);
        end
    endtask

    task automatic test_reset_mid();
        req = 3'b001; we = 3'b000; addr[0] = 16'($urandom);
        tick();
        checks++; if (obs !== exp_v || gnt !== 3'b001) begin fails++; $display("FAIL mid_issue got %h want %h", obs, exp_v); end
        #1 reset = 1'b0;
        #1;
        checks++; if (obs !== 57'h0) begin fails++; $display("FAIL mid_async got %h want 0", obs); end
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (obs !== 57'h0) begin fails++; $display("FAIL mid_hold got %h want 0", obs); end
        end
        @(negedge clk); reset = 1'b1; model_reset();
        checks++; if (obs !== exp_v) begin fails++; $display("FAIL mid_release got %h want %h", obs, exp_v); end
        tick();
        checks++; if (obs !== exp_v || gnt !== 3'b001) begin fails++; $display("FAIL mid_regrant got %h want %h", obs, exp_v); end
        req = 3'b000;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL mid_drain c%0d got %h want %h", cyc, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL rand c%0d got %h want %h", cyc, obs, exp_v); end
            for (int i = 0; i < 3; i++) begin
                if (req[i] && !gnt[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else begin
                    req[i] = $urandom_range(0, i == 2 ? 7 : 2) == 0;
                    we[i] = 1'($urandom);
                    addr[i] = 16'($urandom);
                    wdata[i] = 16'($urandom);
                end
            end
        end
        req = 3'b000;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            checks++; if (obs !== exp_v) begin fails++; $display("FAIL rand_drain c%0d got %h want %h", cyc, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write();
        test_priority();
        test_late_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
